// File: rtl/lcd_bus_responder.sv
// HD44780-style responder for the RS/RW/E/data LCD bus: decodes writes, tracks address and busy, answers reads.
// Optional 4-bit nibble transfer mode is compiled in with `define LCD_RESP_4BIT_EN.
module lcd_bus_responder #(
  parameter int unsigned BUSY_CYCLES  = 2000,
  parameter int unsigned CLEAR_CYCLES = 80000
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       lcd_RS,
  input  logic       lcd_RW,
  input  logic       lcd_E,
  input  logic [7:0] lcd_data_in,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  output logic       char_valid,
  output logic [7:0] char_data,
  output logic [6:0] char_addr,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic       busy,
  output logic       overrun
);

  localparam int unsigned MAX_CYCLES = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYCLES);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES);

  typedef enum logic [1:0] {IDLE, WR_LATCH, RD_DRIVE} state_t;
  state_t state, state_n;

  logic [1:0]       e_sync, rs_sync, rw_sync;
  logic [7:0]       d_meta, d_sync;
  logic             e_prev, e_rise, e_fall, rs_s, rw_s;
  logic [6:0]       addr, dec_addr;
  logic             inc_dec, dec_id;
  logic [CNT_W-1:0] busy_cnt, dec_load;
  logic [7:0]       rd_hold, wr_byte;
  logic             wr_accept, wr_complete, rd_start, rd_end, rd_first;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      e_sync  <= '0;
      rs_sync <= '0;
      rw_sync <= '0;
      d_meta  <= '0;
      d_sync  <= '0;
      e_prev  <= 1'b0;
    end else begin
      e_sync  <= {e_sync[0], lcd_E};
      rs_sync <= {rs_sync[0], lcd_RS};
      rw_sync <= {rw_sync[0], lcd_RW};
      d_meta  <= lcd_data_in;
      d_sync  <= d_meta;
      e_prev  <= e_sync[1];
    end
  end

  assign rs_s   = rs_sync[1];
  assign rw_s   = rw_sync[1];
  assign e_rise = e_sync[1] & ~e_prev;
  assign e_fall = ~e_sync[1] & e_prev;

  assign wr_accept   = (state == IDLE) && e_fall && !rw_s;
  assign rd_start    = (state == IDLE) && e_rise && rw_s;
  assign rd_end      = (state == RD_DRIVE) && (e_fall || !rw_s);
  assign busy        = (busy_cnt != '0);
  assign lcd_data_oe = (state == RD_DRIVE);

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) state <= IDLE;
    else             state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (e_fall && !rw_s)     state_n = WR_LATCH;
        else if (e_rise && rw_s) state_n = RD_DRIVE;
      end
      WR_LATCH: state_n = IDLE;
      RD_DRIVE: if (e_fall || !rw_s) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

`ifdef LCD_RESP_4BIT_EN
  logic       four_bit, nib_phase;
  logic [3:0] hi_nib;

  assign wr_byte     = four_bit ? {hi_nib, d_sync[7:4]} : d_sync;
  assign wr_complete = !four_bit || nib_phase;
  assign rd_first    = !nib_phase;
  assign lcd_data_out = !lcd_data_oe ? '0 :
                        !four_bit    ? rd_hold :
                        nib_phase    ? {rd_hold[3:0], 4'h0} : {rd_hold[7:4], 4'h0};

  // Phase returns to the high nibble after every completed write, which also covers mode switches.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      four_bit  <= 1'b0;
      nib_phase <= 1'b0;
      hi_nib    <= '0;
    end else if (wr_accept) begin
      if (!wr_complete) begin
        hi_nib    <= d_sync[7:4];
        nib_phase <= 1'b1;
      end else begin
        nib_phase <= 1'b0;
        if (!busy && !rs_s && wr_byte[7:5] == 3'b001) four_bit <= ~wr_byte[4];
      end
    end else if (rd_end && four_bit) begin
      nib_phase <= ~nib_phase;
    end
  end
`else
  assign wr_byte      = d_sync;
  assign wr_complete  = 1'b1;
  assign rd_first     = 1'b1;
  assign lcd_data_out = lcd_data_oe ? rd_hold : '0;
`endif

  // Display-control, N/F and shift bits reach the display mirror through cmd_code; only
  // state this responder itself acts on is held here.
  always_comb begin
    dec_addr = addr;
    dec_id   = inc_dec;
    dec_load = BUSY_LOAD;
    casez (wr_byte)
      8'b1???????: dec_addr = wr_byte[6:0];
      8'b01??????, 8'b001?????, 8'b00001???: begin end
      8'b0001????: if (!wr_byte[3]) dec_addr = wr_byte[2] ? addr + 7'd1 : addr - 7'd1;
      8'b000001??: dec_id = wr_byte[1];
      8'b0000001?: begin
        dec_addr = '0;
        dec_load = CLEAR_LOAD;
      end
      8'b00000001: begin
        dec_addr = '0;
        dec_id   = 1'b1;
        dec_load = CLEAR_LOAD;
      end
      default: dec_load = '0;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      char_valid <= 1'b0;
      char_data  <= '0;
      char_addr  <= '0;
      cmd_valid  <= 1'b0;
      cmd_code   <= '0;
      overrun    <= 1'b0;
      addr       <= '0;
      inc_dec    <= 1'b1;
      busy_cnt   <= '0;
      rd_hold    <= '0;
    end else begin
      char_valid <= 1'b0;
      cmd_valid  <= 1'b0;
      if (busy) busy_cnt <= busy_cnt - 1'b1;
      if (wr_accept && wr_complete) begin
        if (busy) begin
          overrun <= 1'b1;
        end else if (rs_s) begin
          char_valid <= 1'b1;
          char_data  <= wr_byte;
          char_addr  <= addr;
          addr       <= inc_dec ? addr + 7'd1 : addr - 7'd1;
          busy_cnt   <= BUSY_LOAD;
        end else begin
          cmd_valid <= 1'b1;
          cmd_code  <= wr_byte;
          addr      <= dec_addr;
          inc_dec   <= dec_id;
          busy_cnt  <= dec_load;
        end
      end
      if (rd_start && rd_first) rd_hold <= rs_s ? 8'h00 : {busy, addr};
    end
  end

endmodule
